// File: rtl/jamma_pkg.sv
// Shared constants for the JAMMA connector scan: scan-state encoding, the
// control-byte bit map and the released (all-high) level.
package jamma_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] SET1 = 2'd0;
  localparam logic [STATE_W-1:0] SMP1 = 2'd1;
  localparam logic [STATE_W-1:0] SET2 = 2'd2;
  localparam logic [STATE_W-1:0] SMP2 = 2'd3;

  localparam int unsigned JOY_UP    = 0;
  localparam int unsigned JOY_DOWN  = 1;
  localparam int unsigned JOY_LEFT  = 2;
  localparam int unsigned JOY_RIGHT = 3;
  localparam int unsigned JOY_FIRE  = 4;
  localparam int unsigned JOY_START = 7;

  localparam logic [7:0] JOY_RELEASED = 8'hFF;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: the output takes a new level only after DEBOUNCE
// consecutive strobed samples disagree with it.
module debounce_bit #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk_24M,
  input  logic reset,
  input  logic strobe,
  input  logic sample,
  output logic q
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt;

  // A matching sample clears the run; the counter never passes DEBOUNCE-1.
  always_ff @(posedge clk_24M) begin
    if (reset) begin
      q   <= 1'b1;
      cnt <= '0;
    end else if (strobe) begin
      if (sample == q) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
        q   <= sample;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jamma_joy_scan.sv
// Scans the multiplexed JAMMA connector in a fixed two-phase schedule and
// produces debounced player bytes, coin levels and coin press pulses.
module jamma_joy_scan
  import jamma_pkg::*;
#(
  parameter int unsigned SETTLE   = 15,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk_24M,
  input  logic       reset,
  input  logic [7:0] JJOY,
  input  logic [5:0] JOYSTICK,
  input  logic [1:0] JCOIN,
  output logic       JSELECT,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic [1:0] coin_n,
  output logic [1:0] coin_pulse,
  output logic       scan_valid
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RND_W   = 4;
  localparam int unsigned NUM_DEB = 24;

  if (SETTLE < 3 || SETTLE > 255) begin : g_bad_settle
    $error("jamma_joy_scan: SETTLE out of range 3..255");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("jamma_joy_scan: DEBOUNCE out of range 1..15");
  end

  logic [7:0]         jjoy_s1, jjoy_s2;
  logic [5:0]         joy_s1, joy_s2;
  logic [1:0]         coin_s1, coin_s2;
  logic [STATE_W-1:0] state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               jsel_nxt;
  logic [RND_W-1:0]   rounds;
  logic [1:0]         coin_prev;
  logic               smp1, smp2;
  logic [NUM_DEB-1:0] deb_sample, deb_strobe, deb_q;

  // Two-flop synchronizers; inputs idle high (released).
  always_ff @(posedge clk_24M) begin
    if (reset) begin
      jjoy_s1 <= JOY_RELEASED;
      jjoy_s2 <= JOY_RELEASED;
      joy_s1  <= '1;
      joy_s2  <= '1;
      coin_s1 <= '1;
      coin_s2 <= '1;
    end else begin
      jjoy_s1 <= JJOY;
      jjoy_s2 <= jjoy_s1;
      joy_s1  <= JOYSTICK;
      joy_s2  <= joy_s1;
      coin_s1 <= JCOIN;
      coin_s2 <= coin_s1;
    end
  end

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      state   <= SET1;
      cnt     <= '0;
      JSELECT <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      JSELECT <= jsel_nxt;
    end
  end

  // Settle counter restarts on every state change; JSELECT follows the next state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      SET1: if (cnt == CNT_W'(SETTLE - 1)) begin
        state_nxt = SMP1;
        cnt_nxt   = '0;
      end
      SMP1: begin
        state_nxt = SET2;
        cnt_nxt   = '0;
      end
      SET2: if (cnt == CNT_W'(SETTLE - 1)) begin
        state_nxt = SMP2;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = SET1;
        cnt_nxt   = '0;
      end
    endcase
    jsel_nxt = (state_nxt == SET2) || (state_nxt == SMP2);
  end

  assign smp1 = (state == SMP1);
  assign smp2 = (state == SMP2);

  // Bit map: [7:0] P1 connector, [13:8] DB9, [21:14] P2 connector, [23:22] coins.
  assign deb_sample = {coin_s2, jjoy_s2, joy_s2, jjoy_s2};
  assign deb_strobe = {{10{smp2}}, {14{smp1}}};

  for (genvar i = 0; i < NUM_DEB; i++) begin : g_deb
    debounce_bit #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk_24M (clk_24M),
      .reset   (reset),
      .strobe  (deb_strobe[i]),
      .sample  (deb_sample[i]),
      .q       (deb_q[i])
    );
  end

  assign joystick1  = deb_q[7:0] & {2'b11, deb_q[13:8]};
  assign joystick2  = deb_q[21:14];
  assign coin_n     = deb_q[23:22];
  assign coin_pulse = coin_prev & ~coin_n;

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      coin_prev  <= 2'b11;
      rounds     <= '0;
      scan_valid <= 1'b0;
    end else begin
      coin_prev <= coin_n;
      if (smp2 && rounds != RND_W'(DEBOUNCE)) begin
        rounds <= rounds + 1'b1;
      end
      if (smp2 && rounds == RND_W'(DEBOUNCE - 1)) begin
        scan_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/jamma_joy_scan.md
# jamma_joy_scan

Scans the multiplexed JAMMA control connector and produces clean, debounced per-player control bytes and coin events for the arcade core.
- Drives the connector's JSELECT line in a fixed two-phase schedule and waits a settle interval after each switch.
- Samples, synchronizes and debounces both players' 8-bit inputs plus the two coin lines.
- Sits directly upstream of the core's control mapping, which consumes joystick1/joystick2/coin_n.
- Replaces the free-running toggle-and-latch joystick logic in the board top level.

## Interface
Parameters:
- SETTLE, 15: cycles held in each settle state after JSELECT changes; legal range 3..255.
- DEBOUNCE, 4: consecutive identical scan samples needed to change a debounced bit; legal range 1..15.

Ports:
- clk_24M  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- JJOY  in  8  connector data, active-low: bit0 up, bit1 down, bit2 left, bit3 right, bit4 fire, bit7 start. Meaning depends on JSELECT.
- JOYSTICK  in  6  local DB9 joystick, active-low; merged into player 1.
- JCOIN  in  2  coin switches, active-low; [0] P1, [1] P2.
- JSELECT  out  1  connector mux select: 0 = player 1, 1 = player 2.
- joystick1  out  8  debounced P1 byte, active-low, merged with DB9.
- joystick2  out  8  debounced P2 byte, active-low.
- coin_n  out  2  debounced coin levels, active-low.
- coin_pulse  out  2  one-cycle high on each debounced coin press.
- scan_valid  out  1  high once outputs reflect real input.

## Operation
- Input capture: JJOY, JOYSTICK and JCOIN each pass through a 2-flop synchronizer before any use.
- FSM states: SET1 → SMP1 → SET2 → SMP2 → SET1.
  - SET1: JSELECT=0; counter runs 0..SETTLE-1.
  - SMP1: one cycle. Captures synced JJOY as P1 raw, and {2'b11, JOYSTICK} as DB9 raw.
  - SET2: JSELECT=1; counter runs 0..SETTLE-1.
  - SMP2: one cycle. Captures synced JJOY as P2 raw, and synced JCOIN as coin raw.
  - JSELECT is registered from the state, so it changes on the cycle the FSM enters SET1 or SET2.
- Debounce, per bit (8 P1, 6 DB9, 8 P2, 2 coin):
  - Each bit has a saturating counter, 4 bits wide.
  - It advances only at that bit's sample strobe.
  - Sample == current output: counter clears.
  - Sample != output: counter increments. When it reaches DEBOUNCE, the output takes the sample and the counter clears.
- Merge: joystick1 = P1_deb & DB9_deb, bitwise. A press on either source reads as pressed.
- coin_pulse[i] is high for the single cycle where coin_n[i] goes 1→0. Release produces no pulse.
- scan_valid:
  - Set when the round counter reaches DEBOUNCE completed SMP2 states after reset.
  - Stays set until reset.
- Reset (any time, including mid-settle or at a sample):
  - FSM goes to SET1 with the settle counter at 0 and JSELECT=0.
  - joystick1 = joystick2 = 8'hFF, coin_n = 2'b11, coin_pulse = 0, scan_valid = 0.
  - All debounce counters, raw registers and synchronizers are set to 1 / 0 as appropriate.
- Out-of-range parameters are caught by an elaboration-time check (simulation $error).

## Timing
- Round length: 2·(SETTLE+1) cycles; 32 cycles by default, i.e. 1.33 µs at 24 MHz.
- After JSELECT switches, the synchronized connector data has SETTLE−2 cycles of margin before sampling. This is why SETTLE ≥ 3.
- Worst-case press-to-output latency for a stable input: 2 sync cycles, plus up to 1 round to the next sample strobe, plus (DEBOUNCE−1) rounds, plus 1 register cycle.
- An input change shorter than DEBOUNCE consecutive samples never reaches the outputs.
- coin_pulse asserts in the same cycle coin_n falls.
- Sampling and debouncing happen in one pipeline stage: the debounced output updates in the cycle after SMP.
- Counter wrap: the settle counter reloads to 0 on every state change. The round counter saturates at DEBOUNCE.

## Structure
- Shared package jamma_pkg holds:
  - state enum {SET1, SMP1, SET2, SMP2};
  - JAMMA bit-index constants (UP=0, DOWN=1, LEFT=2, RIGHT=3, FIRE=4, START=7);
  - the released-value constant 8'hFF.
- One natural sub-module, debounce_bit: a single-bit saturating-counter debouncer with a sample-strobe input.
  - Parameterized by DEBOUNCE.
  - Instantiated 24 times via generate.

## Test plan
- Reset release with all inputs held at 1:
  - JSELECT toggles at cycles 16 and 32 after the sync delay, with period 32 (default parameters).
  - Outputs stay at 8'hFF; scan_valid rises at the end of round 4.
- Steady P1 connector value 8'hFE (up) while JSELECT=0 and 8'hFF while JSELECT=1 → joystick1 becomes 8'hFE after 4 rounds; joystick2 stays 8'hFF.
- JOYSTICK=6'b101111 (fire) with JJOY all 1s → joystick1 = 8'hEF. Adding P1 connector bit0 low → 8'hEE.
- Glitch on P2 start lasting 3 rounds, then released → joystick2 never leaves 8'hFF. The same glitch lasting 4 rounds → bit7 goes low.
- JCOIN[1] pressed for 10 rounds, then released:
  - exactly one coin_pulse[1] cycle, coincident with coin_n[1] falling;
  - no pulse on release; coin_pulse[0] stays 0 throughout.
- reset asserted for 1 cycle while in SET2 with joystick1 = 8'hFE:
  - next cycle: JSELECT=0, all outputs back to their released values, scan_valid=0;
  - the schedule restarts from SET1.
